// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, NOP default and handshake helper for the IF/ID skid stage.
package pipe_pkg;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;
    function automatic logic fire(input logic valid, input logic ready);
        return valid & ready;
    endfunction
endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: one instruction+pc+valid holding register with load and clear.
module pipe_entry #(
    parameter int IW = 32,
    parameter int PW = 9,
    parameter logic [IW-1:0] NOP = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic          i_clear,
    input  logic [IW-1:0] i_inst,
    input  logic [PW-1:0] i_pc,
    output logic          o_valid,
    output logic [IW-1:0] o_inst,
    output logic [PW-1:0] o_pc
);
    logic          r_valid;
    logic [IW-1:0] r_inst;
    logic [PW-1:0] r_pc;
    // clear keeps the pc so pc_out holds its last value while invalid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_inst  <= NOP;
            r_pc    <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_inst  <= NOP;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_inst  <= i_inst;
            r_pc    <= i_pc;
        end
    end
    assign o_valid = r_valid;
    assign o_inst  = r_inst;
    assign o_pc    = r_pc;
endmodule

// File: rtl/stage_if_id_skid.sv
// stage_if_id_skid: IF/ID register with a 2-entry skid buffer, valid/ready handshake and flush.
// Optional stall/flush counters enabled by defining IF_ID_STATS_EN.
module stage_if_id_skid
    import pipe_pkg::*;
#(
    parameter int INST_WIDTH = 32,
    parameter int IMEM_ADDR_WIDTH = 9,
    parameter logic [INST_WIDTH-1:0] NOP_INST = INST_WIDTH'(NOP_DEFAULT)
`ifdef IF_ID_STATS_EN
    , parameter int CNT_WIDTH = 16
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INST_WIDTH-1:0]      inst_in,
    input  logic [IMEM_ADDR_WIDTH-1:0] pc_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INST_WIDTH-1:0]      inst_out,
    output logic [IMEM_ADDR_WIDTH-1:0] pc_out
`ifdef IF_ID_STATS_EN
    , output logic [CNT_WIDTH-1:0]     stall_cnt
    , output logic [CNT_WIDTH-1:0]     flush_cnt
`endif
);
    state_t                     r_state, w_next;
    logic                       r_in_ready;
    logic                       w_in_fire, w_out_fire, w_bad;
    logic                       w_main_load, w_main_clr, w_skid_load, w_skid_clr;
    logic                       w_main_valid, w_skid_valid;
    logic [INST_WIDTH-1:0]      w_main_inst, w_skid_inst, w_main_d_inst;
    logic [IMEM_ADDR_WIDTH-1:0] w_main_pc, w_skid_pc, w_main_d_pc;

    always_comb begin
        w_in_fire     = fire(in_valid, r_in_ready);
        w_out_fire    = fire(w_main_valid, out_ready);
        w_bad         = !(r_state inside {EMPTY, ONE, FULL});
        w_main_load   = !flush & (r_state == EMPTY ? w_in_fire :
                                  r_state == ONE   ? w_in_fire & w_out_fire :
                                  r_state == FULL  & w_out_fire);
        w_skid_load   = !flush & (r_state == ONE) & w_in_fire & !w_out_fire;
        w_main_clr    = flush | w_bad | ((r_state == ONE) & !w_in_fire & w_out_fire);
        w_skid_clr    = flush | w_bad | ((r_state == FULL) & w_out_fire);
        w_main_d_inst = r_state == FULL ? w_skid_inst : inst_in;
        w_main_d_pc   = r_state == FULL ? w_skid_pc : pc_in;
        w_next        = (flush | w_bad)  ? EMPTY :
                        r_state == EMPTY ? (w_in_fire ? ONE : EMPTY) :
                        r_state == ONE   ? (w_skid_load ? FULL : (w_out_fire & !w_in_fire) ? EMPTY : ONE) :
                        (w_out_fire ? ONE : FULL);
    end

    // in_ready tracks the next skid valid so it never depends on out_ready combinationally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= !(w_skid_load | (w_skid_valid & !w_skid_clr));
        end
    end

    pipe_entry #(.IW(INST_WIDTH), .PW(IMEM_ADDR_WIDTH), .NOP(NOP_INST)) u_main (
        .clk(clk), .reset(reset), .i_load(w_main_load), .i_clear(w_main_clr),
        .i_inst(w_main_d_inst), .i_pc(w_main_d_pc),
        .o_valid(w_main_valid), .o_inst(w_main_inst), .o_pc(w_main_pc)
    );

    pipe_entry #(.IW(INST_WIDTH), .PW(IMEM_ADDR_WIDTH), .NOP(NOP_INST)) u_skid (
        .clk(clk), .reset(reset), .i_load(w_skid_load), .i_clear(w_skid_clr),
        .i_inst(inst_in), .i_pc(pc_in),
        .o_valid(w_skid_valid), .o_inst(w_skid_inst), .o_pc(w_skid_pc)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = w_main_valid;
    assign inst_out  = w_main_valid ? w_main_inst : NOP_INST;
    assign pc_out    = w_main_pc;

`ifdef IF_ID_STATS_EN
    logic [CNT_WIDTH-1:0] r_stall_cnt, r_flush_cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_main_valid & !out_ready & ~&r_stall_cnt) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (flush & w_main_valid & ~&r_flush_cnt) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif
endmodule

// File: tb/tb_stage_if_id_skid.sv
// tb_stage_if_id_skid: scoreboard bench for the IF/ID skid stage; FIFO reference model per cycle.
module tb_stage_if_id_skid;
    logic        clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] inst_in = '0;
    logic [8:0]  pc_in = '0;
    logic        in_ready, out_valid;
    logic [31:0] inst_out;
    logic [8:0]  pc_out;
`ifdef IF_ID_STATS_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif
    typedef struct packed {logic [31:0] inst; logic [8:0] pc;} ent_t;
    ent_t q[$];
    int checks = 0, passed = 0, delivered = 0;

    stage_if_id_skid dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .inst_in(inst_in), .pc_in(pc_in),
        .out_valid(out_valid), .out_ready(out_ready), .inst_out(inst_out), .pc_out(pc_out)
`ifdef IF_ID_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // compares outputs against the model at the negedge, then advances one cycle
    task automatic step();
        checks++;
        if (out_valid !== (q.size() != 0)) $display("FAIL step_out_valid got=%0b want=%0b", out_valid, q.size() != 0);
        else passed++;
        checks++;
        if (in_ready !== (q.size() < 2)) $display("FAIL step_in_ready got=%0b want=%0b", in_ready, q.size() < 2);
        else passed++;
        checks++;
        if (q.size() == 0 ? inst_out !== 32'h0 : {inst_out, pc_out} !== q[0])
            $display("FAIL step_data got=%h/%0d want=%h", inst_out, pc_out, q.size() == 0 ? 41'h0 : q[0]);
        else passed++;
        if (out_valid && out_ready && q.size() != 0) begin
            void'(q.pop_front());
            delivered++;
        end
        if (flush) q.delete();
        else if (in_valid && in_ready) q.push_back({inst_in, pc_in});
        @(negedge clk);
    endtask

    task automatic test_stream();
        int d0 = delivered;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; inst_in = 32'h11111111 * (i + 1); pc_in = 9'(i);
            step();
        end
        in_valid = 1'b0;
        step(); step();
        checks++;
        if (delivered - d0 !== 4) $display("FAIL stream_count got=%0d want=4", delivered - d0);
        else passed++;
    endtask

    task automatic test_reset();
        out_ready = 1'b0; in_valid = 1'b1; inst_in = 32'hCAFE0001; pc_in = 9'd7;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || inst_out !== 32'hCAFE0001) $display("FAIL reset_pre got=%0b/%h want=1/cafe0001", out_valid, inst_out);
        else passed++;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, inst_out, pc_out, in_ready} !== 43'h0) $display("FAIL reset_async got=%0b/%h/%0d/%0b want=0/0/0/0", out_valid, inst_out, pc_out, in_ready);
        else passed++;
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL reset_release got=%0b/%0b want=1/0", in_ready, out_valid);
        else passed++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1;
        inst_in = 32'hAAAA0001; pc_in = 9'd5; step();
        inst_in = 32'hAAAA0002; pc_in = 9'd6; step();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || inst_out !== 32'hAAAA0001) $display("FAIL bp_full got=%0b/%h want=0/aaaa0001", in_ready, inst_out);
        else passed++;
        step();
        out_ready = 1'b1;
        step(); step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL bp_drain got=%0b/%0b want=1/0", in_ready, out_valid);
        else passed++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        inst_in = 32'hBBBB0001; pc_in = 9'd10; step();
        inst_in = 32'hBBBB0002; pc_in = 9'd11; step();
        flush = 1'b1; inst_in = 32'hBBBB0003; pc_in = 9'd12; step();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || inst_out !== 32'h0 || in_ready !== 1'b1) $display("FAIL flush_full got=%0b/%h/%0b want=0/0/1", out_valid, inst_out, in_ready);
        else passed++;
        out_ready = 1'b1; step(); step();
        in_valid = 1'b1; flush = 1'b1; inst_in = 32'hBBBB0004; pc_in = 9'd13; step();
        in_valid = 1'b0; flush = 1'b0; step();
        in_valid = 1'b1; inst_in = 32'hBBBB0005; pc_in = 9'd14; step();
        flush = 1'b1; inst_in = 32'hBBBB0006; pc_in = 9'd15; step();
        flush = 1'b0; in_valid = 1'b0; step(); step();
    endtask

    task automatic test_simul();
        out_ready = 1'b0; in_valid = 1'b1; inst_in = 32'hDDDD0001; pc_in = 9'd20; step();
        out_ready = 1'b1; inst_in = 32'hDDDD0002; pc_in = 9'd21; step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || inst_out !== 32'hDDDD0002 || pc_out !== 9'd21 || in_ready !== 1'b1)
            $display("FAIL simul_one got=%0b/%h/%0d/%0b want=1/dddd0002/21/1", out_valid, inst_out, pc_out, in_ready);
        else passed++;
        step(); step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
            inst_in = $urandom; pc_in = 9'($urandom);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step(); step(); step();
    endtask

`ifdef IF_ID_STATS_EN
    task automatic test_stats();
        #2 reset = 1'b1;
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) $display("FAIL stats_reset got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
        else passed++;
        out_ready = 1'b0; in_valid = 1'b1;
        inst_in = 32'hEEEE0001; pc_in = 9'd30; step();
        inst_in = 32'hEEEE0002; pc_in = 9'd31; step();
        in_valid = 1'b0; step();
        flush = 1'b1; step();
        step();
        flush = 1'b0;
        checks++;
        if (stall_cnt !== 16'd3 || flush_cnt !== 16'd1) $display("FAIL stats_counts got=%0d/%0d want=3/1", stall_cnt, flush_cnt);
        else passed++;
    endtask
`endif

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || inst_out !== 32'h0 || pc_out !== 9'd0)
            $display("FAIL initial_reset got=%0b/%0b/%h/%0d want=1/0/0/0", in_ready, out_valid, inst_out, pc_out);
        else passed++;
        test_stream();
        test_reset();
        test_backpressure();
        test_flush();
        test_simul();
        test_back_to_back();
`ifdef IF_ID_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/stage_if_id_skid.md
Name: stage_if_id_skid

Overview:
Parametrised IF/ID pipeline register. It latches the fetched instruction and its PC through a 2-entry skid buffer with a valid/ready handshake and a synchronous flush. Sits between the fetch stage (imem read) and decode. When the stage holds no valid entry it presents a NOP, so decode never sees stale data. Unlike a plain enable-gated register, back-pressure from decode never drops a fetched instruction.

Parameters:
INST_WIDTH, 32, instruction word width
IMEM_ADDR_WIDTH, 9, PC (instruction memory address) width
NOP_INST, 0, instruction value driven on inst_out when out_valid=0
CNT_WIDTH, 16, width of the optional statistics counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
flush  in  1  synchronous squash of all held entries (branch taken)
in_valid  in  1  fetch presents inst_in/pc_in
in_ready  out  1  stage can accept this cycle
inst_in  in  INST_WIDTH  fetched instruction
pc_in  in  IMEM_ADDR_WIDTH  PC of inst_in
out_valid  out  1  inst_out/pc_out valid to decode
out_ready  in  1  decode consumes this cycle
inst_out  out  INST_WIDTH  instruction to decode
pc_out  out  IMEM_ADDR_WIDTH  PC of inst_out

Behaviour:
- Reset: async; clears all valids; main and skid inst registers <= NOP_INST; PCs <= 0; out_valid=0; inst_out=NOP_INST; pc_out=0; in_ready=0 while reset is asserted, 1 on the first cycle after release.
- Handshake:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Data is transferred only on a fire.
  - Inputs are don't-care when in_valid=0.
- in_ready = !skid_valid. It is registered (no combinational path from out_ready).
- out_valid = main_valid.
- inst_out = main_valid ? main_inst : NOP_INST.
- pc_out = main_pc. It holds its last value while invalid.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty.
- States and transitions:
  - EMPTY: in_fire -> ONE (main <= in); otherwise EMPTY.
  - ONE:
    - in_fire & out_fire -> ONE (main <= in).
    - in_fire & !out_fire -> FULL (skid <= in; main holds).
    - !in_fire & out_fire -> EMPTY.
    - Neither fire -> ONE (hold).
  - FULL: in_ready=0. out_fire -> ONE (main <= skid; skid cleared). Otherwise FULL (hold).
- Ordering is strictly FIFO. main is always the older entry.
- Flush has priority over everything:
  - Next state is EMPTY; both valids cleared; main_inst <= NOP_INST.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle is still a legal consume by decode.
- A flush asserted while the stage is EMPTY has no effect.
- Reset asserted mid-transfer aborts immediately. No partial update survives.
- Full throughput: with out_ready=1 held high, one instruction per cycle passes and the skid buffer stays unused.
- No arithmetic. PC is carried unmodified, no wrap logic.

Optional Feature:
Macro IF_ID_STATS_EN.
- Defined: adds outputs stall_cnt [CNT_WIDTH] and flush_cnt [CNT_WIDTH].
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - flush_cnt increments on each flush that squashes at least one valid entry.
  - Both counters saturate at all-ones and reset to 0.
- Not defined: the ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package pipe_pkg:
  - state encoding EMPTY=2'd0, ONE=2'd1, FULL=2'd2 (2'd3 illegal -> EMPTY);
  - NOP constant default;
  - handshake fire macros-as-functions.
- Sub-module pipe_entry: one inst+pc+valid register with load/clear, instantiated twice (main, skid).

Test Plan:
1. Reset: assert reset mid-simulation with data held -> same cycle out_valid=0, inst_out=0x00000000, pc_out=0, in_ready=0; in_ready=1 one cycle after release.
2. Streaming: out_ready=1; feed inst 0x11111111..0x44444444 with pc 0..3 back-to-back -> each appears one cycle later, in order; in_ready stays 1.
3. Back-pressure:
   - Stimulus: feed 0xAAAA0001 (pc 5) then 0xAAAA0002 (pc 6) with out_ready=0.
   - Response: in_ready=0 after the second transfer; inst_out holds 0xAAAA0001.
   - Then raise out_ready for 2 cycles -> 0xAAAA0001 then 0xAAAA0002 delivered; in_ready=1.
4. Flush while FULL, with a simultaneous in_valid of 0xBBBB0003 -> next cycle out_valid=0, inst_out=NOP_INST, in_ready=1; 0xBBBB0003 is never delivered.
5. Simultaneous in_fire and out_fire in state ONE -> state stays ONE; new inst appears next cycle; no skid use.
6. With IF_ID_STATS_EN: 3 stall cycles plus 1 flush squashing 2 entries plus 1 flush on EMPTY -> stall_cnt=3, flush_cnt=1.
